// File: rtl/sdram_responder_model.sv
// BRAM-backed stand-in for the SDRAM memory controller: level read/write/refresh
// commands with a busy handshake, active-low byte mask and optional clear-on-reset.
module sdram_responder_model #(
   parameter int ADDR_WIDTH     = 12,
   parameter int LATENCY        = 2,
   parameter int REFRESH_CYCLES = 4,
   parameter int INIT_CLEAR     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic        refresh,
   input  logic [31:0] addr,
   input  logic [31:0] din,
   input  logic [3:0]  mask,
   output logic [31:0] dout,
   output logic        busy,
   output logic        mem_initialized,
   output logic        fail
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY} state_t;
   typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_REFRESH} op_t;

   state_t                state, state_next;
   op_t                   op, op_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic [ADDR_WIDTH-1:0] sweep, sweep_next;
   logic                  busy_next, init_next, fail_next;
   logic [2:0]            cmd, cmd_prev;
   logic                  any_cmd, multi_cmd;

   logic [ADDR_WIDTH-1:0] idx;
   logic [31:0]           wdata;
   logic [3:0]            wmask;

   logic                  mem_we, mem_re;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;
   logic [3:0]            mem_be;
   logic [31:0]           mem [DEPTH];

   // Byte offset and address bits above the array alias onto the same words.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

   assign cmd       = {refresh, write, read};
   assign any_cmd   = |cmd;
   assign multi_cmd = (read & write) | (read & refresh) | (write & refresh);

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= (INIT_CLEAR != 0) ? S_INIT : S_IDLE;
         busy            <= (INIT_CLEAR != 0);
         mem_initialized <= (INIT_CLEAR == 0);
         fail            <= 1'b0;
         sweep           <= '0;
         cnt             <= '0;
         op              <= OP_READ;
         cmd_prev        <= 3'b000;
      end else begin
         state           <= state_next;
         busy            <= busy_next;
         mem_initialized <= init_next;
         fail            <= fail_next;
         sweep           <= sweep_next;
         cnt             <= cnt_next;
         op              <= op_next;
         cmd_prev        <= cmd;
      end
   end

   // Request operands, captured once at acceptance and held for the whole command.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && any_cmd) begin
         idx   <= addr[ADDR_WIDTH+1:2];
         wdata <= din;
         wmask <= mask;
      end
   end

   always_comb begin
      state_next = state;
      op_next    = op;
      cnt_next   = cnt;
      sweep_next = sweep;
      busy_next  = busy;
      init_next  = mem_initialized;
      fail_next  = fail;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = idx;
      mem_wdata  = wdata;
      mem_be     = ~wmask;
      case (state)
         S_INIT: begin
            mem_we     = 1'b1;
            mem_addr   = sweep;
            mem_wdata  = '0;
            mem_be     = 4'hF;
            sweep_next = sweep + 1'b1;
            if (sweep == '1) begin
               busy_next  = 1'b0;
               init_next  = 1'b1;
               state_next = S_IDLE;
            end
         end
         S_IDLE: begin
            if (any_cmd) begin
               state_next = S_BUSY;
               busy_next  = 1'b1;
               if (multi_cmd) fail_next = 1'b1;
               if (write) begin
                  op_next  = OP_WRITE;
                  cnt_next = CNT_W'(LATENCY);
               end else if (read) begin
                  op_next  = OP_READ;
                  cnt_next = CNT_W'(LATENCY);
               end else begin
                  op_next  = OP_REFRESH;
                  cnt_next = CNT_W'(REFRESH_CYCLES);
               end
            end
         end
         S_BUSY: begin
            if ((cmd & ~cmd_prev) != 3'b000) fail_next = 1'b1;
            if (cnt == '0) begin
               busy_next  = 1'b0;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  mem_re = (op == OP_READ);
                  mem_we = (op == OP_WRITE);
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
      // A reset edge aborts the command before it can touch the array.
      if (rst) begin
         mem_we = 1'b0;
         mem_re = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) dout <= '0;
      else if (mem_re) dout <= mem[mem_addr];
   end

endmodule

// File: tb/tb_sdram_responder_model.sv
// Directed bench for sdram_responder_model: two instances (clear-on-reset and
// retain-on-reset) against a timestamp-based behavioural model.
module tb_sdram_responder_model;

   localparam int AW  = 4;
   localparam int LAT = 2;
   localparam int REF = 4;
   localparam int NW  = 1 << AW;

   logic        clk = 1'b0;
   logic        rst0 = 1'b1, rst1 = 1'b1;
   logic        read = 1'b0, write = 1'b0, refresh = 1'b0;
   logic [31:0] addr = '0, din = '0;
   logic [3:0]  mask = 4'hF;
   logic [31:0] dout0, dout1;
   logic        busy0, busy1, init0, init1, fail0, fail1;

   always #5 clk = ~clk;

   sdram_responder_model #(.ADDR_WIDTH(AW), .LATENCY(LAT), .REFRESH_CYCLES(REF), .INIT_CLEAR(1)) u0 (
      .clk(clk), .rst(rst0), .read(read), .write(write), .refresh(refresh), .addr(addr),
      .din(din), .mask(mask), .dout(dout0), .busy(busy0), .mem_initialized(init0), .fail(fail0));

   sdram_responder_model #(.ADDR_WIDTH(AW), .LATENCY(LAT), .REFRESH_CYCLES(REF), .INIT_CLEAR(0)) u1 (
      .clk(clk), .rst(rst1), .read(read), .write(write), .refresh(refresh), .addr(addr),
      .din(din), .mask(mask), .dout(dout1), .busy(busy1), .mem_initialized(init1), .fail(fail1));

   logic        act = 1'b0;
   logic        cmp_en = 1'b0;
   logic [31:0] c_dout;
   logic        c_busy, c_init, c_fail;
   assign c_dout = act ? dout1 : dout0;
   assign c_busy = act ? busy1 : busy0;
   assign c_init = act ? init1 : init0;
   assign c_fail = act ? fail1 : fail0;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
      end
   endtask

   // Behavioural model: commands are timestamped at acceptance; the memory
   // effect lands LATENCY edges later and busy drops one edge after that.
   logic [31:0] mm [NW];
   bit          known [NW];
   int          cyc = 0, init_end = 0, t_commit = 0, t_end = 0;
   bit          pend = 0, last_act = 0;
   int          p_op = 0, p_idx = 0;
   logic [31:0] p_d = '0;
   logic [3:0]  p_m = '0;
   logic [2:0]  prev = '0;
   logic        e_busy = 0, e_init = 0, e_fail = 0, e_dout_known = 1;
   logic [31:0] e_dout = '0;

   always @(posedge clk) begin : model
      logic       r_a;
      logic [2:0] cmd;
      cyc++;
      r_a = act ? rst1 : rst0;
      cmd = {refresh, write, read};
      if (act != last_act) begin
         for (int i = 0; i < NW; i++) known[i] = 0;
         last_act = act;
      end
      if (r_a) begin
         pend = 0; e_dout = '0; e_dout_known = 1; e_fail = 0; prev = '0;
         if (!act) begin
            e_busy = 1; e_init = 0; init_end = cyc + NW;
            for (int i = 0; i < NW; i++) begin mm[i] = '0; known[i] = 1; end
         end else begin
            e_busy = 0; e_init = 1;
         end
      end else begin
         if (!e_init) begin
            if (cyc == init_end) begin e_busy = 0; e_init = 1; end
         end else if (pend) begin
            if ((cmd & ~prev) != 3'b000) e_fail = 1;
            if (cyc == t_commit) begin
               if (p_op == 1) begin
                  for (int b = 0; b < 4; b++)
                     if (!p_m[b]) mm[p_idx][8*b +: 8] = p_d[8*b +: 8];
                  if (p_m == 4'b0000) known[p_idx] = 1;
               end else if (p_op == 0) begin
                  e_dout = mm[p_idx]; e_dout_known = known[p_idx];
               end
            end
            if (cyc == t_end) begin e_busy = 0; pend = 0; end
         end else if (cmd != 3'b000) begin
            pend = 1; e_busy = 1;
            if ($countones(cmd) > 1) e_fail = 1;
            p_op  = write ? 1 : (read ? 0 : 2);
            p_idx = int'(addr[AW+1:2]);
            p_d   = din; p_m = mask;
            t_commit = cyc + ((p_op == 2) ? REF : LAT);
            t_end    = t_commit + 1;
         end
         prev = cmd;
      end
   end

   always begin : compare
      @(posedge clk);
      #2;
      if (cmp_en) begin
         chk("busy", 32'(c_busy), 32'(e_busy));
         chk("mem_initialized", 32'(c_init), 32'(e_init));
         chk("fail", 32'(c_fail), 32'(e_fail));
         if (e_dout_known) chk("dout", c_dout, e_dout);
      end
   end

   task automatic start_cmd(input logic r, input logic w, input logic f,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      int g;
      @(negedge clk);
      read = r; write = w; refresh = f; addr = a; din = d; mask = m;
      g = 0;
      do begin @(negedge clk); g++; end while (!c_busy && g < 50);
      read = 0; write = 0; refresh = 0;
      if (g >= 50) begin
         total++; bad++;
         $display("FAIL accept_timeout: busy never rose at %0t", $time);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (c_busy && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) begin
         total++; bad++;
         $display("FAIL done_timeout: busy stuck high at %0t", $time);
      end
   endtask

   task automatic do_cmd(input string nm, input logic r, input logic w, input logic f,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input int exp_busy);
      int n;
      start_cmd(r, w, f, a, d, m);
      wait_done(n);
      chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_busy));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      repeat (3) @(negedge clk);
      cmp_en = 1;
      chk("rst_busy", 32'(busy0), 32'd1);
      chk("rst_init", 32'(init0), 32'd0);
      chk("rst_dout", dout0, 32'h0);
      chk("rst_fail", 32'(fail0), 32'd0);
      rst0 = 0;
      n = 0;
      while (busy0 && n < 100) begin n++; @(negedge clk); end
      chk("init_busy_cycles", 32'(n), 32'd16);
      chk("init_done", 32'(init0), 32'd1);

      do_cmd("rd_clear", 1, 0, 0, 32'h14, 0, 4'hF, 3);
      chk("rd_clear_dout", dout0, 32'h0);
      do_cmd("wr8", 0, 1, 0, 32'h8, 32'hDEADBEEF, 4'b0000, 3);
      do_cmd("rd8", 1, 0, 0, 32'h8, 0, 4'hF, 3);
      chk("rd8_dout", dout0, 32'hDEADBEEF);
      do_cmd("wr8_b2", 0, 1, 0, 32'h8, 32'h00AA0000, 4'b1011, 3);
      do_cmd("rd8_b2", 1, 0, 0, 32'h8, 0, 4'hF, 3);
      chk("rd8_b2_dout", dout0, 32'hDEAABEEF);
      do_cmd("wr8_nop", 0, 1, 0, 32'h8, 32'hFFFFFFFF, 4'b1111, 3);
      do_cmd("rd8_nop", 1, 0, 0, 32'h8, 0, 4'hF, 3);
      chk("rd8_nop_dout", dout0, 32'hDEAABEEF);

      do_cmd("wr4", 0, 1, 0, 32'h4, 32'h11223344, 4'b0000, 3);
      do_cmd("wr4_hi", 0, 1, 0, 32'h4, 32'hCC000000, 4'b0111, 3);
      do_cmd("wr8_lo", 0, 1, 0, 32'h8, 32'h000000DD, 4'b1110, 3);
      do_cmd("rd4", 1, 0, 0, 32'h4, 0, 4'hF, 3);
      chk("split_word1", dout0, 32'hCC223344);
      do_cmd("rd8_split", 1, 0, 0, 32'h8, 0, 4'hF, 3);
      chk("split_word2_lo", 32'(dout0[7:0]), 32'hDD);

      do_cmd("wr_top", 0, 1, 0, 32'h3C, 32'h0F0F0F0F, 4'b0000, 3);
      do_cmd("wr_wrap", 0, 1, 0, 32'h40, 32'hA5A5A5A5, 4'b0000, 3);
      do_cmd("rd_w0", 1, 0, 0, 32'h0, 0, 4'hF, 3);
      chk("wrap_word0", dout0, 32'hA5A5A5A5);
      do_cmd("rd_top", 1, 0, 0, 32'h3C, 0, 4'hF, 3);
      chk("top_word", dout0, 32'h0F0F0F0F);
      do_cmd("rd_alias", 1, 0, 0, 32'h1000_0004, 0, 4'hF, 3);
      chk("alias_word1", dout0, 32'hCC223344);

      do_cmd("refresh", 0, 0, 1, 32'h4, 0, 4'hF, 5);
      chk("refresh_dout", dout0, 32'hCC223344);
      chk("fail_clean", 32'(fail0), 32'd0);
      do_cmd("rw_both", 1, 1, 0, 32'h10, 32'h12345678, 4'b0000, 3);
      chk("rw_fail", 32'(fail0), 32'd1);
      chk("rw_dout_kept", dout0, 32'hCC223344);
      do_cmd("rd10", 1, 0, 0, 32'h10, 0, 4'hF, 3);
      chk("rw_write_won", dout0, 32'h12345678);
      chk("fail_sticky", 32'(fail0), 32'd1);

      start_cmd(0, 1, 0, 32'h18, 32'h55555555, 4'b0000);
      rst0 = 1;
      @(negedge clk);
      chk("abort_busy", 32'(busy0), 32'd1);
      chk("abort_init", 32'(init0), 32'd0);
      chk("abort_fail", 32'(fail0), 32'd0);
      chk("abort_dout", dout0, 32'h0);

      cmp_en = 0; act = 1;
      repeat (2) @(negedge clk);
      rst1 = 0; cmp_en = 1;
      chk("r1_busy", 32'(busy1), 32'd0);
      chk("r1_init", 32'(init1), 32'd1);
      do_cmd("u1_wr20", 0, 1, 0, 32'h20, 32'h55AA55AA, 4'b0000, 3);
      start_cmd(1, 0, 0, 32'h20, 0, 4'hF);
      refresh = 1;
      @(negedge clk);
      refresh = 0;
      wait_done(n);
      chk("rise_fail", 32'(fail1), 32'd1);
      chk("rise_rd_dout", dout1, 32'h55AA55AA);

      do_cmd("u1_wr24", 0, 1, 0, 32'h24, 32'h77777777, 4'b0000, 3);
      start_cmd(0, 1, 0, 32'h20, 32'h99999999, 4'b0000);
      rst1 = 1;
      @(negedge clk);
      rst1 = 0;
      chk("r1_abort_busy", 32'(busy1), 32'd0);
      chk("r1_abort_init", 32'(init1), 32'd1);
      chk("r1_abort_fail", 32'(fail1), 32'd0);
      chk("r1_abort_dout", dout1, 32'h0);
      do_cmd("u1_rd24", 1, 0, 0, 32'h24, 0, 4'hF, 3);
      chk("retained_word", dout1, 32'h77777777);
      do_cmd("u1_rd20", 1, 0, 0, 32'h20, 0, 4'hF, 3);
      chk("aborted_write_lost", dout1, 32'h55AA55AA);

      @(negedge clk);
      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sdram_responder_model.md
Name: sdram_responder_model

Overview:
- Synthesizable, BRAM-backed responder for the word-wide memory-controller interface: read/write/refresh level commands, a busy handshake, and an active-low byte mask.
- Stands in for the SDRAM MemoryController when the DRAM front-end is run on FPGAs without SDRAM and in fast simulation.
- Answers exactly the request/busy protocol the front-end issues, including the split unaligned accesses it sequences as two word operations.

Parameters:
- ADDR_WIDTH, 12, word-address bits; memory holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2, cycles busy stays high after the acceptance cycle for read/write; minimum 1.
- REFRESH_CYCLES, 4, cycles busy stays high after acceptance of a refresh; minimum 1.
- INIT_CLEAR, 1, 1 = zero every word after reset before mem_initialized rises; 0 = skip the sweep.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- read, input, 1, read command, level, held by requester until busy seen.
- write, input, 1, write command, level, same rule.
- refresh, input, 1, refresh command, level, same rule.
- addr, input, 32, byte address; bits [ADDR_WIDTH+1:2] select the word; [1:0] and upper bits ignored (upper bits alias).
- din, input, 32, write data, byte lanes aligned to word.
- mask, input, 4, active-low byte-write mask; mask[i]=0 writes din[8i+7:8i].
- dout, output, 32, read data; valid from the busy falling edge until the next read completes.
- busy, output, 1, high while a command is in progress or init is running.
- mem_initialized, output, 1, high once the init sweep is done.
- fail, output, 1, sticky protocol-violation flag, cleared only by rst.

Behaviour:
Reset (rst=1 on a clk edge):
- State INIT when INIT_CLEAR=1; IDLE otherwise.
- busy=1 if INIT, else 0. mem_initialized=0 if INIT, else 1.
- dout=0, fail=0, sweep counter=0.
- Reset mid-operation aborts the command. Memory contents are not restored; a partial write that has not yet been committed is lost.

INIT:
- Writes 0 to word[cnt] each cycle, cnt 0..2^ADDR_WIDTH-1.
- After the last word: busy=0 and mem_initialized=1 on the same edge; state goes to IDLE.
- Commands seen during INIT are ignored and do not set fail. Requesters must wait for mem_initialized.

IDLE:
- When any command is high, latch addr word index, din, mask and the command type. Next edge: busy=1, counter=LATENCY (or REFRESH_CYCLES), state goes to BUSY.
- Priority when more than one command is high: write > read > refresh. Only the winner executes; fail is set.

BUSY:
- Command inputs are ignored except for the fail check below.
- Counter decrements each cycle.
- At counter==1:
  - read: dout <= mem[idx].
  - write: bytes with mask[i]=0 are updated; mask=4'b1111 is a legal no-op write.
  - refresh: no memory effect.
- At counter==0: busy=0, state goes to IDLE.
- Acceptance to busy fall is LATENCY+1 cycles (REFRESH_CYCLES+1 for refresh), so the requester always sees busy before completion.

Back-to-back:
- A command still high in IDLE on the cycle after busy falls is accepted as a new command. Requesters must drop commands on seeing busy.
- Two sequential word accesses (idx, then idx+1) need no special handling. An index at 2^ADDR_WIDTH-1 followed by +1 wraps to 0.

dout:
- Changes only on read completion; unchanged by write or refresh.

Memory:
- Single-port BRAM inference: one read or one byte-masked write per cycle, registered output.

fail:
- Set on simultaneous commands at acceptance.
- Set on a new rising edge of any command while in BUSY (previous-cycle sample was 0, now 1).

Test Plan:
- Reset with INIT_CLEAR=1, ADDR_WIDTH=4 -> busy high for exactly 16 cycles after reset deassert, then mem_initialized=1 and busy=0; a read of any address returns 0.
- write addr=0x8, din=0xDEADBEEF, mask=4'b0000, then read addr=0x8 -> busy high LATENCY+1 cycles per op; dout=0xDEADBEEF at the busy fall.
- Byte masks on word 0x8 (0xDEADBEEF): write din=0x00AA0000 with mask=4'b1011 -> read gives 0xDEAABEEF; mask=4'b1111 write -> contents unchanged.
- Split unaligned store:
  - Write 0x11223344 to addr 0x4, mask 4'b0000.
  - Write din=0xCC000000, mask 4'b0111, to addr 0x4.
  - Write din=0x000000DD, mask 4'b1110, to addr 0x8.
  - Required: word1=0xCC223344 and the word at 0x8 has low byte 0xDD.
- refresh with REFRESH_CYCLES=4 -> busy high 5 cycles, dout unchanged, memory unchanged. read and write raised in the same cycle -> write executes, fail=1 and stays 1 until rst.
- Reset asserted during BUSY of a write -> busy returns to INIT/IDLE values; a write completed before the reset edge is retained after a re-init with INIT_CLEAR=0.
